// File: rtl/cstl_scramble_map.sv
// rtl/cstl_scramble_map.sv - Gray constellation mapper with LFSR-driven k*90 deg phase scrambling
//
// cstl_lfsr9: 9-bit Fibonacci LFSR (x^9+x^5+1) with synchronous reseed.
//   clk, rst   : clock, async active-high reset (state -> SEED)
//   step       : advance one position
//   reseed     : with step, load SEED instead of the stepped value
//   state      : current register contents
//
// cstl_scramble_map: two-stage mapper feeding the IFFT input buffer.
//   clk, rst   : clock, async active-high reset
//   di         : tone word (16QAM uses di[3:0], QPSK uses di[3:2])
//   di_vld     : tone word valid, single-cycle pulses
//   di_sym_end : last sub-carrier of the OFDM symbol, qualified by di_vld
//   err_clr    : clears sc_err
//   do_re      : rotated in-phase sample, signed OW bits
//   do_im      : rotated quadrature sample, signed OW bits
//   do_vld     : output valid, two clocks after di_vld
//   do_sym_end : symbol end, aligned with do_vld
//   sc_err     : sticky symbol/sub-carrier alignment error

module cstl_lfsr9 #(
  parameter logic [8:0] SEED = 9'h1FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       reseed,
  output logic [8:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (step) begin
      state <= reseed ? SEED : {state[7:0], state[8] ^ state[4]};
    end
  end

endmodule

module cstl_scramble_map #(
  parameter int          QAM16    = 1,
  parameter int          N_SC     = 256,
  parameter int          OW       = 8,
  parameter int          UNIT     = 32,
  parameter int          QPSK_AMP = 64,
  parameter logic [8:0]  SEED     = 9'h1FF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           di,
  input  logic                 di_vld,
  input  logic                 di_sym_end,
  input  logic                 err_clr,
  output logic signed [OW-1:0] do_re,
  output logic signed [OW-1:0] do_im,
  output logic                 do_vld,
  output logic                 do_sym_end,
  output logic                 sc_err
);

  localparam int CW = (N_SC > 1) ? $clog2(N_SC) : 1;

  localparam logic signed [OW-1:0] LVL_1 = OW'(UNIT);
  localparam logic signed [OW-1:0] LVL_3 = OW'(3 * UNIT);
  localparam logic signed [OW-1:0] LVL_Q = OW'(QPSK_AMP);

  // Gray pair, first-received bit is the MSB: 00,01,11,10 -> -3U,-U,+U,+3U
  function automatic logic signed [OW-1:0] gray16(input logic b_first, input logic b_second);
    logic signed [OW-1:0] lvl;
    case ({b_first, b_second})
      2'b00:   lvl = -LVL_3;
      2'b01:   lvl = -LVL_1;
      2'b11:   lvl = LVL_1;
      default: lvl = LVL_3;
    endcase
    return lvl;
  endfunction

  logic [8:0]           lfsr;
  logic [CW-1:0]        sc_cnt;
  logic                 last_sc;
  logic                 early_end;
  logic                 miss_end;
  logic signed [OW-1:0] map_i;
  logic signed [OW-1:0] map_q;

  logic                 s1_vld;
  logic                 s1_end;
  logic signed [OW-1:0] s1_i;
  logic signed [OW-1:0] s1_q;
  logic [1:0]           s1_r;

  // The last sub-carrier of a symbol still uses the pre-reseed rotation code,
  // because r is sampled from the current state before the reseed lands.
  cstl_lfsr9 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (di_vld),
    .reseed (di_vld & di_sym_end),
    .state  (lfsr)
  );

  assign last_sc   = (sc_cnt == CW'(N_SC - 1));
  assign early_end = di_vld &  di_sym_end & ~last_sc;
  assign miss_end  = di_vld & ~di_sym_end &  last_sc;

  always_comb begin
    map_i = '0;
    map_q = '0;
    if (QAM16 != 0) begin
      map_i = gray16(di[0], di[1]);
      map_q = gray16(di[2], di[3]);
    end else begin
      map_i = di[2] ? LVL_Q : -LVL_Q;
      map_q = di[3] ? LVL_Q : -LVL_Q;
    end
  end

  // Sub-carrier counter and sticky alignment error. A missing end wraps the
  // count so the next symbol starts fresh, but does not reseed the LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_cnt <= '0;
      sc_err <= 1'b0;
    end else begin
      if (di_vld) begin
        if (di_sym_end || last_sc) begin
          sc_cnt <= '0;
        end else begin
          sc_cnt <= sc_cnt + 1'b1;
        end
      end
      if (early_end || miss_end) begin
        sc_err <= 1'b1;
      end else if (err_clr) begin
        sc_err <= 1'b0;
      end
    end
  end

  // Stage 1: Gray map, capture rotation code alongside the sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_end <= 1'b0;
      s1_i   <= '0;
      s1_q   <= '0;
      s1_r   <= 2'd0;
    end else begin
      s1_vld <= di_vld;
      s1_end <= di_vld & di_sym_end;
      if (di_vld) begin
        s1_i <= map_i;
        s1_q <= map_q;
        s1_r <= lfsr[1:0];
      end
    end
  end

  // Stage 2: rotate by r*90 deg; samples hold when no valid arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_vld     <= 1'b0;
      do_sym_end <= 1'b0;
      do_re      <= '0;
      do_im      <= '0;
    end else begin
      do_vld     <= s1_vld;
      do_sym_end <= s1_end;
      if (s1_vld) begin
        case (s1_r)
          2'd0: begin
            do_re <= s1_i;
            do_im <= s1_q;
          end
          2'd1: begin
            do_re <= -s1_q;
            do_im <= s1_i;
          end
          2'd2: begin
            do_re <= -s1_i;
            do_im <= -s1_q;
          end
          default: begin
            do_re <= s1_q;
            do_im <= -s1_i;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cstl_scramble_map.sv
// tb/tb_cstl_scramble_map.sv - directed table-driven bench for cstl_scramble_map

module tb_cstl_scramble_map;

  localparam int OW_T   = 8;
  localparam int UNIT_T = 32;
  localparam int AMP_T  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] di;
  logic       di_vld;
  logic       di_sym_end;
  logic       err_clr;

  // index 0: defaults, 1: SEED=1FC, 2: N_SC=8, 3: QPSK
  logic [3:0][OW_T-1:0] re_a;
  logic [3:0][OW_T-1:0] im_a;
  logic [3:0]           vld_a;
  logic [3:0]           se_a;
  logic [3:0]           err_a;

  cstl_scramble_map #(.QAM16(1), .N_SC(256), .OW(OW_T), .UNIT(UNIT_T), .QPSK_AMP(AMP_T), .SEED(9'h1FF)) u_def (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .di_sym_end(di_sym_end), .err_clr(err_clr),
    .do_re(re_a[0]), .do_im(im_a[0]), .do_vld(vld_a[0]), .do_sym_end(se_a[0]), .sc_err(err_a[0]));

  cstl_scramble_map #(.QAM16(1), .N_SC(256), .OW(OW_T), .UNIT(UNIT_T), .QPSK_AMP(AMP_T), .SEED(9'h1FC)) u_seed (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .di_sym_end(di_sym_end), .err_clr(err_clr),
    .do_re(re_a[1]), .do_im(im_a[1]), .do_vld(vld_a[1]), .do_sym_end(se_a[1]), .sc_err(err_a[1]));

  cstl_scramble_map #(.QAM16(1), .N_SC(8), .OW(OW_T), .UNIT(UNIT_T), .QPSK_AMP(AMP_T), .SEED(9'h1FF)) u_nsc8 (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .di_sym_end(di_sym_end), .err_clr(err_clr),
    .do_re(re_a[2]), .do_im(im_a[2]), .do_vld(vld_a[2]), .do_sym_end(se_a[2]), .sc_err(err_a[2]));

  cstl_scramble_map #(.QAM16(0), .N_SC(256), .OW(OW_T), .UNIT(UNIT_T), .QPSK_AMP(AMP_T), .SEED(9'h1FF)) u_qpsk (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld), .di_sym_end(di_sym_end), .err_clr(err_clr),
    .do_re(re_a[3]), .do_im(im_a[3]), .do_vld(vld_a[3]), .do_sym_end(se_a[3]), .sc_err(err_a[3]));

  typedef struct {
    logic       rst_first;
    int         dut;
    logic       v;
    logic [3:0] d;
    logic       se;
    int         er;
    int         ei;
    logic       ese;
  } vec_t;

  vec_t tbl[$];

  int n_chk = 0;
  int n_err = 0;

  logic  p_v   = 1'b0;
  int    p_dut = 0;
  int    p_er  = 0;
  int    p_ei  = 0;
  logic  p_ese = 1'b0;
  string p_tag = "none";

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sre(input int dut);
    return int'($signed(re_a[dut]));
  endfunction

  function automatic int sim(input int dut);
    return int'($signed(im_a[dut]));
  endfunction

  // Applies one input cycle. Outputs seen after the following negedge belong
  // to the input applied by the previous call (two posedges of latency).
  task automatic drive(input int dut, input logic v, input logic [3:0] d, input logic se,
                       input int er, input int ei, input logic ese, input string tag);
    di         = d;
    di_vld     = v;
    di_sym_end = se;
    @(negedge clk);
    chk({p_tag, "_vld"}, int'(vld_a[p_dut]), int'(p_v));
    if (p_v) begin
      chk({p_tag, "_re"}, sre(p_dut), p_er);
      chk({p_tag, "_im"}, sim(p_dut), p_ei);
      chk({p_tag, "_sym_end"}, int'(se_a[p_dut]), int'(p_ese));
    end
    p_v   = v;
    p_dut = dut;
    p_er  = er;
    p_ei  = ei;
    p_ese = ese;
    p_tag = tag;
  endtask

  task automatic idle(input string tag);
    drive(p_dut, 1'b0, 4'b0000, 1'b0, 0, 0, 1'b0, tag);
  endtask

  task automatic do_reset();
    idle("flush");
    rst        = 1'b1;
    di_vld     = 1'b0;
    di_sym_end = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    p_v = 1'b0;
  endtask

  task automatic add(input logic r, input int dut, input logic [3:0] d, input logic se,
                     input int er, input int ei, input logic ese);
    vec_t x;
    x.rst_first = r;
    x.dut       = dut;
    x.v         = 1'b1;
    x.d         = d;
    x.se        = se;
    x.er        = er;
    x.ei        = ei;
    x.ese       = ese;
    tbl.push_back(x);
  endtask

  initial begin
    if (3 * UNIT_T >= (1 << (OW_T - 1)) || AMP_T >= (1 << (OW_T - 1))) begin
      $display("FAIL param_range: levels exceed signed %0d-bit output", OW_T);
      $fatal(1);
    end

    // Rotation code sequence from SEED 1FF: 1FF,1FE,1FC,1F8,1F0,1E0,1C1,183,107,00F,01E
    // gives r = 3,2,0,0,0,0,1,3,3,3,2. With d=0000 (16QAM) I=Q=-96, so
    // r0=(-96,-96) r1=(96,-96) r2=(96,96) r3=(-96,96).

    // defaults, three back-to-back zero words
    add(1, 0, 4'b0000, 0, -96,  96, 0);
    add(0, 0, 4'b0000, 0,  96,  96, 0);
    add(0, 0, 4'b0000, 0, -96, -96, 0);
    // asymmetric word 4'b0010: I=-32, Q=-96
    add(1, 0, 4'b0010, 0, -96,  32, 0);
    add(0, 0, 4'b0010, 0,  32,  96, 0);
    add(0, 0, 4'b0010, 0, -32, -96, 0);
    // Gray table with SEED=1FC (r=0), sym_end each word; di[0] is first bit of I pair
    add(1, 1, 4'b0000, 1, -96, -96, 1);
    add(0, 1, 4'b1010, 1, -32, -32, 1);
    add(0, 1, 4'b1111, 1,  32,  32, 1);
    add(0, 1, 4'b0101, 1,  96,  96, 1);
    add(0, 1, 4'b0010, 1, -32, -96, 1);
    add(0, 1, 4'b1000, 1, -96, -32, 1);
    // QPSK: I from di[2], Q from di[3]
    add(1, 3, 4'b1100, 0,  64, -64, 0);
    add(0, 3, 4'b0100, 0, -64,  64, 0);
    add(0, 3, 4'b1011, 0, -64,  64, 0);
    add(0, 3, 4'b0111, 0,  64, -64, 0);
    add(0, 3, 4'b0000, 0, -64, -64, 0);
    add(0, 3, 4'b0000, 0, -64, -64, 0);
    add(0, 3, 4'b0000, 0,  64, -64, 0);
    // N_SC=8 full symbol, then first word of the next symbol repeats the first output
    add(1, 2, 4'b0000, 0, -96,  96, 0);
    add(0, 2, 4'b0000, 0,  96,  96, 0);
    add(0, 2, 4'b0000, 0, -96, -96, 0);
    add(0, 2, 4'b0000, 0, -96, -96, 0);
    add(0, 2, 4'b0000, 0, -96, -96, 0);
    add(0, 2, 4'b0000, 0, -96, -96, 0);
    add(0, 2, 4'b0000, 0,  96, -96, 0);
    add(0, 2, 4'b0000, 1, -96,  96, 1);
    add(0, 2, 4'b0000, 0, -96,  96, 0);

    rst        = 1'b1;
    di         = 4'b0000;
    di_vld     = 1'b0;
    di_sym_end = 1'b0;
    err_clr    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_re%0d", k), sre(k), 0);
      chk($sformatf("reset_im%0d", k), sim(k), 0);
      chk($sformatf("reset_vld%0d", k), int'(vld_a[k]), 0);
      chk($sformatf("reset_se%0d", k), int'(se_a[k]), 0);
      chk($sformatf("reset_err%0d", k), int'(err_a[k]), 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) do_reset();
      drive(tbl[i].dut, tbl[i].v, tbl[i].d, tbl[i].se, tbl[i].er, tbl[i].ei, tbl[i].ese,
            $sformatf("vec%0d", i));
    end
    idle("vec_tail");
    chk("nsc8_full_symbol_err", int'(err_a[2]), 0);

    // sym_end without valid is ignored; outputs hold while idle
    do_reset();
    drive(0, 1'b1, 4'b0000, 1'b0, -96, 96, 1'b0, "ign_a");
    drive(0, 1'b0, 4'b0000, 1'b1, 0, 0, 1'b0, "ign_idle_se");
    idle("ign_idle");
    chk("hold_re", sre(0), -96);
    chk("hold_im", sim(0), 96);
    drive(0, 1'b1, 4'b0000, 1'b0, 96, 96, 1'b0, "ign_b");
    idle("ign_tail");
    chk("ign_err", int'(err_a[0]), 0);

    // early end on 5th word, then missing end, then err_clr handling (N_SC=8)
    do_reset();
    drive(2, 1'b1, 4'b0000, 1'b0, -96,  96, 1'b0, "early1");
    drive(2, 1'b1, 4'b0000, 1'b0,  96,  96, 1'b0, "early2");
    drive(2, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "early3");
    drive(2, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "early4");
    drive(2, 1'b1, 4'b0000, 1'b1, -96, -96, 1'b1, "early5");
    chk("early_err", int'(err_a[2]), 1);
    drive(2, 1'b1, 4'b0000, 1'b0, -96,  96, 1'b0, "miss1");
    drive(2, 1'b1, 4'b0000, 1'b0,  96,  96, 1'b0, "miss2");
    drive(2, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "miss3");
    drive(2, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "miss4");
    drive(2, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "miss5");
    drive(2, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "miss6");
    drive(2, 1'b1, 4'b0000, 1'b0,  96, -96, 1'b0, "miss7");
    drive(2, 1'b1, 4'b0000, 1'b0, -96,  96, 1'b0, "miss8");
    drive(2, 1'b1, 4'b0000, 1'b0, -96,  96, 1'b0, "miss9");
    drive(2, 1'b1, 4'b0000, 1'b0, -96,  96, 1'b0, "miss10");
    drive(2, 1'b1, 4'b0000, 1'b0,  96,  96, 1'b0, "miss11");
    idle("miss_tail");
    chk("miss_err_sticky", int'(err_a[2]), 1);
    err_clr = 1'b1;
    idle("clr");
    err_clr = 1'b0;
    chk("err_cleared", int'(err_a[2]), 0);
    // new early end (count 3) coincident with err_clr: the error wins
    err_clr = 1'b1;
    drive(2, 1'b1, 4'b0000, 1'b1, 96, -96, 1'b1, "clr_vs_err");
    err_clr = 1'b0;
    chk("err_wins_over_clr", int'(err_a[2]), 1);
    idle("clr_vs_err_tail");
    err_clr = 1'b1;
    idle("clr2");
    err_clr = 1'b0;
    chk("err_cleared2", int'(err_a[2]), 0);

    // reset while a sample is in flight drops it; sc_cnt and LFSR restart
    do_reset();
    drive(0, 1'b1, 4'b0000, 1'b0, 0, 0, 1'b0, "inflight");
    rst        = 1'b1;
    di_vld     = 1'b0;
    di_sym_end = 1'b0;
    #1;
    chk("rst_async_vld", int'(vld_a[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    p_v = 1'b0;
    idle("post_rst1");
    idle("post_rst2");
    drive(0, 1'b1, 4'b0000, 1'b0, -96,  96, 1'b0, "rs1");
    drive(0, 1'b1, 4'b0000, 1'b0,  96,  96, 1'b0, "rs2");
    drive(0, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "rs3");
    drive(0, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "rs4");
    drive(0, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "rs5");
    drive(0, 1'b1, 4'b0000, 1'b0, -96, -96, 1'b0, "rs6");
    drive(0, 1'b1, 4'b0000, 1'b0,  96, -96, 1'b0, "rs7");
    drive(0, 1'b1, 4'b0000, 1'b1, -96,  96, 1'b1, "rs8");
    idle("rs_tail");
    chk("rst_sc_cnt_restart", int'(err_a[2]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
